sq_frame_accum_32: RTL and testbench
====================================

// Module: sq_frame_accum_32
// PURPOSE
// - Downstream consumer of the 32-bit (y+1)^2 combinational stage. Accepts its results as a
//   valid/ready stream and sums FRAME_LEN consecutive samples into one wide frame total.
// - Emits each total with a valid/ready handshake. Holds the total until it is taken (backpressure).
// - Partial frames are emitted on request via flush.
// PARAMETERS
// - DATA_W     32  width of each input sample
// - ACC_W      40  accumulator and out_sum width; must be >= DATA_W
// - FRAME_LEN  4   samples per frame, >= 1
// - CNT_W (localparam) = $clog2(FRAME_LEN+1)
// PORTS
// - clk        in   1       rising-edge clock
// - rst        in   1       asynchronous, active-high reset
// - in_valid   in   1       in_data is valid
// - in_ready   out  1       block accepts in_data this cycle
// - in_data    in   DATA_W  sample, unsigned
// - flush      in   1       close the current partial frame
// - out_valid  out  1       frame result is valid
// - out_ready  in   1       downstream takes the result
// - out_sum    out  ACC_W   frame sum
// - out_count  out  CNT_W   number of samples in the emitted frame
// - out_ovf    out  1       accumulation overflowed during the frame
// BEHAVIOUR
// - Reset (async, immediate):
//   - state=ACCUM; acc=0; cnt=0; ovf=0.
//   - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
// - in_ready = (state==ACCUM), combinational. An accept is in_valid & in_ready.
// - State ACCUM:
//   - On accept: acc <= acc + in_data (zero-extended); cnt <= cnt+1; ovf |= carry out of ACC_W.
//   - Frame closes when an accept brings cnt to FRAME_LEN, or when flush=1 with (cnt>0 or an accept).
//   - A flush in the same cycle as an accept includes that sample.
//   - flush with cnt==0 and no accept is ignored.
//   - On close: out_sum <= updated acc; out_count <= updated cnt; out_ovf <= updated ovf;
//     out_valid <= 1; state <= HOLD. Outputs change on the next edge (1-cycle latency after the last accept).
// - State HOLD:
//   - in_ready=0; flush is ignored.
//   - out_sum, out_count and out_ovf stay stable while out_valid & !out_ready.
//   - On out_ready: out_valid <= 0; acc, cnt, ovf <= 0; state <= ACCUM.
//   - out_sum, out_count and out_ovf keep their last values after the handshake.
// - No bypass from HOLD to accept in the same cycle. Minimum frame period is FRAME_LEN+1 cycles.
// - Arithmetic is unsigned. Sums wrap modulo 2^ACC_W unless saturation is enabled.
// - Reset mid-frame discards the partial frame and any pending result.
// CONFIGURATION
// - SQ_ACCUM_SATURATE_EN:
//   - Defined: on carry out, acc clamps to 2^ACC_W-1 and stays clamped for the rest of the frame;
//     ovf=1.
//   - Undefined: acc wraps modulo 2^ACC_W; ovf=1 (sticky for the frame).
// TESTING
// - Frame: 121,16,1,4 with out_ready=1 -> out_sum=142, out_count=4, out_ovf=0,
//   out_valid high exactly 1 cycle.
// - Backpressure: after a frame closes, hold out_ready=0 for 5 cycles -> out_sum stays 142,
//   in_ready=0, input samples are not consumed.
// - Flush: 121,16 then flush=1 -> out_sum=137, out_count=2. A flush with an empty frame
//   produces no output.
// - Wrap (ACC_W=33, macro undefined): 4 x 0xFFFFFFFF -> out_sum=0x1FFFFFFFC, out_ovf=1.
//   Saturate (macro defined) -> 0x1FFFFFFFF, out_ovf=1.
// - Reset after 2 samples of a frame, then 1,1,1,1 -> out_sum=4, out_count=4
//   (no residue from the aborted frame).

Source files
------------

// File: rtl/sq_frame_accum_32.sv
// sq_frame_accum_32
//   Sums FRAME_LEN consecutive unsigned samples from the (y+1)^2 stage into
//   one wide frame total. A frame also closes early when flush is asserted
//   while it holds at least one sample, or while a sample is being accepted.
//   A closed frame is held on the output until out_ready is seen. No new
//   samples are accepted while a result is held.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data is valid
//   in_ready   the block accepts in_data this cycle
//   in_data    unsigned sample, DATA_W bits
//   flush      close the current partial frame
//   out_valid  a frame result is valid
//   out_ready  downstream takes the result
//   out_sum    frame sum, ACC_W bits
//   out_count  number of samples in the emitted frame
//   out_ovf    the accumulation overflowed during the frame
//
// Build option
//   SQ_ACCUM_SATURATE_EN  when defined, the accumulator clamps to 2^ACC_W-1 on
//                         a carry out and stays clamped for the rest of the
//                         frame. When undefined, the sum wraps modulo 2^ACC_W.
//                         out_ovf is sticky for the frame in both builds.

module sq_frame_accum_32 #(
    parameter  int DATA_W    = 32,
    parameter  int ACC_W     = 40,
    parameter  int FRAME_LEN = 4,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic [ACC_W:0]   in_ext;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             close;

    assign in_ready = (state == ST_ACCUM);
    assign accept   = in_valid & in_ready;

    // The extension is always at least one bit wide, even when ACC_W == DATA_W.
    assign in_ext  = {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
    assign sum_ext = {1'b0, acc} + in_ext;
    assign carry   = sum_ext[ACC_W];

    // Values after this cycle's accept. They are also what a closing frame
    // reports, so the last sample is included without an extra cycle.
    always_comb begin
        // NOTE: every output gets a default first so that no path leaves it unassigned (no latch).
        acc_nxt = acc;
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (accept) begin
`ifdef SQ_ACCUM_SATURATE_EN
            // Once clamped, any later nonzero sample carries again, so the
            // clamp holds for the rest of the frame without extra state.
            acc_nxt = carry ? '1 : sum_ext[ACC_W-1:0];
`else
            acc_nxt = sum_ext[ACC_W-1:0];
`endif
            cnt_nxt = cnt + CNT_W'(1);
            ovf_nxt = ovf | carry;
        end
    end

    // A flush with an empty frame and no accept is ignored.
    assign close = (state == ST_ACCUM) &&
                   ((accept && (cnt_nxt == FRAME_CNT)) ||
                    (flush && ((cnt != '0) || accept)));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (state == ST_ACCUM) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            if (close) begin
                out_sum   <= acc_nxt;
                out_count <= cnt_nxt;
                out_ovf   <= ovf_nxt;
                out_valid <= 1'b1;
                state     <= ST_HOLD;
            end
        end else begin
            // The result registers keep their last values after the
            // handshake. Only the frame state is cleared.
            if (out_ready) begin
                out_valid <= 1'b0;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
                state     <= ST_ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_sq_frame_accum_32.sv
// Testbench for sq_frame_accum_32 (ACC_W = 33 so the wrap and saturate
// boundary is reachable with four full-scale samples).

module tb_sq_frame_accum_32;

    localparam int DATA_W    = 32;
    localparam int ACC_W     = 33;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

`ifdef SQ_ACCUM_SATURATE_EN
    localparam logic [63:0] WRAP_EXP = 64'h1_FFFF_FFFF;
`else
    localparam logic [63:0] WRAP_EXP = 64'h1_FFFF_FFFC;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    sq_frame_accum_32 #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    // Behavioural model: a pending flag, the list of samples taken in the
    // current frame, and the last emitted result computed by plain arithmetic.
    bit               m_pending = 1'b0;
    longint unsigned  m_q[$];
    logic [ACC_W-1:0] m_sum = '0;
    int               m_cnt = 0;
    bit               m_ovf = 1'b0;
    bit               m_took;
    longint unsigned  m_total;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pending = 1'b0;
            m_q.delete();
            m_sum = '0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (!m_pending) begin
            m_took = in_valid;
            if (m_took) m_q.push_back(longint'(in_data));
            if ((m_took && m_q.size() == FRAME_LEN) || (flush && m_q.size() > 0)) begin
                m_total = 0;
                foreach (m_q[i]) m_total += m_q[i];
                m_ovf = (m_total > ACC_MAX);
`ifdef SQ_ACCUM_SATURATE_EN
                m_sum = m_ovf ? ACC_W'(ACC_MAX) : ACC_W'(m_total);
`else
                m_sum = ACC_W'(m_total);
`endif
                m_cnt = m_q.size();
                m_q.delete();
                m_pending = 1'b1;
            end
        end else if (out_ready) begin
            m_pending = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("in_ready",  64'(in_ready),  64'(!m_pending));
        check("out_valid", 64'(out_valid), 64'(m_pending));
        check("out_sum",   64'(out_sum),   64'(m_sum));
        check("out_count", 64'(out_count), 64'(m_cnt));
        check("out_ovf",   64'(out_ovf),   64'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] v, input bit with_flush);
        int  k = 0;
        bit  took;
        in_valid = 1'b1;
        in_data  = v;
        flush    = with_flush;
        do begin
            took = in_ready;
            step();
            k++;
        end while (!took && k < 50);
        if (!took) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [63:0] sum,
                               input logic [63:0] cnt, input logic [63:0] ovf);
        int k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_sum"},   64'(out_sum),   sum);
        check({name, "_count"}, 64'(out_count), cnt);
        check({name, "_ovf"},   64'(out_ovf),   ovf);
    endtask

    initial begin
        // Reset state.
        #1 rst = 1'b1;
        step();
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sum",   64'(out_sum),   64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_ovf",   64'(out_ovf),   64'd0);
        check("rst_ready", 64'(in_ready),  64'd1);
        rst = 1'b0;
        step();

        // Full frame, consumer always ready: valid for exactly one cycle.
        send(32'd121, 1'b0);
        send(32'd16,  1'b0);
        send(32'd1,   1'b0);
        send(32'd4,   1'b0);
        wait_result("frame", 64'd142, 64'd4, 64'd0);
        step();
        check("valid_one_cycle", 64'(out_valid), 64'd0);

        // Backpressure: result held, a waiting sample is not consumed.
        out_ready = 1'b0;
        send(32'd121, 1'b0);
        send(32'd16,  1'b0);
        send(32'd1,   1'b0);
        send(32'd4,   1'b0);
        wait_result("bp", 64'd142, 64'd4, 64'd0);
        in_valid = 1'b1;
        in_data  = 32'd100;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_in_ready", 64'(in_ready),  64'd0);
            check("bp_hold_sum", 64'(out_sum),   64'd142);
            check("bp_valid",    64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_released",  64'(out_valid), 64'd0);
        check("bp_sum_kept",  64'(out_sum),   64'd142);

        // Flush of a partial frame; the held sample 100 must not appear.
        send(32'd121, 1'b0);
        send(32'd16,  1'b0);
        pulse_flush();
        wait_result("flush", 64'd137, 64'd2, 64'd0);
        step();

        // Flush with an empty frame produces nothing.
        pulse_flush();
        step();
        step();
        check("empty_flush", 64'(out_valid), 64'd0);

        // Flush in the same cycle as an accept includes that sample.
        send(32'd5, 1'b1);
        wait_result("flush_accept", 64'd5, 64'd1, 64'd0);
        step();

        // Overflow at ACC_W = 33.
        for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 1'b0);
        wait_result("wrap", WRAP_EXP, 64'd4, 64'd1);
        step();

        // Reset mid-frame discards the partial sum.
        send(32'd7, 1'b0);
        send(32'd9, 1'b0);
        rst = 1'b1;
        step();
        check("midrst_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
        wait_result("after_rst", 64'd4, 64'd4, 64'd0);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
